pbtn_event_gen: RTL and testbench
=================================

Name: pbtn_event_gen

Overview:
- Sits directly downstream of the push-button debouncer and consumes its debounced button vector.
- Converts button levels into single-cycle press and release pulses.
- Provides per-button auto-repeat while a button is held, sticky event flags with write-1-to-clear, and a saturating press counter.
- Outputs feed the GPIO/AHB register block and the software-visible button event logic.

Parameters:
- NBTN, 6, number of buttons (width of the debounced input vector).
- REPEAT_DELAY, 50000000, cycles a button must stay held before the first repeat (0.5 s at 100 MHz); must be ≥2.
- REPEAT_RATE, 10000000, cycles between subsequent repeats (0.1 s at 100 MHz); must be ≥2.
- CNT_W, 8, press counter width.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  reset; asynchronous, active-high
- pbtn_db  input  NBTN  debounced button levels, 1 = pressed; synchronous to clk
- rpt_en  input  1  auto-repeat enable
- evt_clr  input  NBTN  write-1-to-clear strobes for evt_sticky
- cnt_clr  input  1  clears press_count
- press_pulse  output  NBTN  one-cycle press event (initial press or repeat)
- release_pulse  output  NBTN  one-cycle release event
- evt_sticky  output  NBTN  latched press flags
- btn_held  output  NBTN  registered copy of pbtn_db
- press_count  output  CNT_W  saturating count of press_pulse events

Behaviour:
- Reset (async assert, sync release): all outputs 0; internal previous-level register 0; all per-button FSMs IDLE; repeat counters 0.
- Edge detect:
  - btn_held <= pbtn_db each cycle.
  - A rise means btn_held=0 and pbtn_db=1 at edge k. A fall means btn_held=1 and pbtn_db=0 at edge k.
  - All outputs are registered; latency from an input change sampled at edge k is one cycle (output valid k..k+1).
- Per-button FSM, states IDLE, HOLD, REPEAT:
  - IDLE, rise at edge k: press_pulse[i]=1 for one cycle; counter loaded with REPEAT_DELAY-1; go to HOLD.
  - HOLD, still held:
    - Counter decrements each cycle.
    - At counter==0: if rpt_en=1, press_pulse[i]=1 for one cycle. This happens at edge k+REPEAT_DELAY.
    - Go to REPEAT and reload the counter with REPEAT_RATE-1 regardless of rpt_en.
  - REPEAT, still held: counter decrements. At 0, pulse if rpt_en=1 and reload REPEAT_RATE-1. Pulses occur at k+REPEAT_DELAY+n·REPEAT_RATE.
  - Any state, fall: release_pulse[i]=1 for one cycle; go to IDLE; counter cleared. A release on the same edge the counter expires produces release_pulse only, no repeat pulse.
  - A rise while not IDLE is not possible, since a fall always returns the FSM to IDLE. A glitch that rises one cycle after a fall is treated as a new press.
  - Toggling rpt_en mid-hold only gates pulse emission; counters keep running.
- Sticky flags:
  - evt_sticky[i] is set on the same edge that press_pulse[i] is driven high.
  - evt_clr[i] clears it.
  - Simultaneous set and clear: set wins (flag stays 1).
- Press counter:
  - Each edge, press_count increments by the popcount of the press_pulse bits being asserted.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr together with new pulses: result equals that cycle's popcount.
- Buttons are independent; any number may pulse in the same cycle.
- Reset asserted mid-hold: immediate return to reset values, with no release_pulse. After reset deasserts with a button still held, the first sampled edge is seen as a rise and produces a press_pulse.

Test Plan (REPEAT_DELAY=20, REPEAT_RATE=5, CNT_W=8):
- Single press: pbtn_db 000000→000001 at edge 10, held 8 cycles, then released → press_pulse=000001 only for cycle 10–11; release_pulse=000001 only for cycle 18–19; evt_sticky=000001; press_count=1.
- Auto-repeat: rpt_en=1, button 3 held from edge 0 for 40 cycles → press_pulse[3] at edges 0, 20, 25, 30, 35; press_count=5. The same stimulus with rpt_en=0 gives only the edge-0 pulse and press_count=1.
- Release on expiry edge: button 2 rises at edge 0 and falls at edge 20 → no repeat pulse at 20; release_pulse[2] at 20.
- Sticky clear race: evt_sticky[1]=1, pulse evt_clr=000010 → flag 0. Then assert evt_clr[1] on the same edge as a new press of button 1 → flag stays 1.
- Counter saturation and multi-press: preload via 254 presses, then press 3 buttons in the same cycle → press_count=255 and stays there. Then cnt_clr together with 2 simultaneous presses → press_count=2.
- Async reset: assert rst mid-REPEAT at a non-clock time → all outputs 0 immediately. Deassert with button held → press_pulse on the first sampled edge.

Source files
------------

// File: rtl/pbtn_event_gen.sv
// pbtn_event_gen: press/release pulses, per-button auto-repeat, sticky press flags
// and a saturating press counter derived from the debounced button vector.
module pbtn_event_gen #(
    parameter int NBTN         = 6,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBTN-1:0]  pbtn_db,
    input  logic             rpt_en,
    input  logic [NBTN-1:0]  evt_clr,
    input  logic             cnt_clr,
    output logic [NBTN-1:0]  press_pulse,
    output logic [NBTN-1:0]  release_pulse,
    output logic [NBTN-1:0]  evt_sticky,
    output logic [NBTN-1:0]  btn_held,
    output logic [CNT_W-1:0] press_count
);
    localparam int CW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam int PW = $clog2(NBTN + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2;

    logic [NBTN-1:0] press_n, release_n;
    logic [PW-1:0]   pop;
    logic [SW-1:0]   sum;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        logic [1:0]    state;
        logic [CW-1:0] cnt;
        logic          rise, fall, active, expire;
        assign rise   = ~btn_held[i] & pbtn_db[i];
        assign fall   = btn_held[i] & ~pbtn_db[i];
        assign active = btn_held[i] & pbtn_db[i] & (state != IDLE);
        assign expire = active & (cnt == '0);
        // a fall on the expiry edge wins: release only, no repeat pulse
        assign press_n[i]   = rise | (expire & rpt_en);
        assign release_n[i] = fall;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (fall) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (rise) begin
                state <= HOLD;
                cnt   <= CW'(REPEAT_DELAY - 1);
            end else if (expire) begin
                state <= REPEAT;
                cnt   <= CW'(REPEAT_RATE - 1);
            end else if (active) begin
                cnt   <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int j = 0; j < NBTN; j++) pop = pop + PW'(press_n[j]);
        sum = (cnt_clr ? SW'(0) : SW'(press_count)) + SW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_held      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            evt_sticky    <= '0;
            press_count   <= '0;
        end else begin
            btn_held      <= pbtn_db;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            evt_sticky    <= (evt_sticky & ~evt_clr) | press_n;
            press_count   <= (sum > SW'(CMAX)) ? CMAX : sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_pbtn_event_gen.sv
// tb_pbtn_event_gen: scoreboard bench; a timing-rule reference model queues the
// expected outputs for every clock edge and a monitor compares after each edge.
module tb_pbtn_event_gen;
    localparam int NB = 6, RD = 20, RR = 5, CW = 8;

    logic          clk = 0, rst = 1, rpt_en = 0, cnt_clr = 0;
    logic [NB-1:0] pbtn_db = '0, evt_clr = '0;
    logic [NB-1:0] press_pulse, release_pulse, evt_sticky, btn_held;
    logic [CW-1:0] press_count;

    pbtn_event_gen #(.NBTN(NB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pbtn_db(pbtn_db), .rpt_en(rpt_en), .evt_clr(evt_clr),
        .cnt_clr(cnt_clr), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .evt_sticky(evt_sticky), .btn_held(btn_held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] press, rel, sticky, held;
        logic [CW-1:0] count;
    } exp_t;

    exp_t          q[$];
    int            checks = 0, errors = 0;
    int            t = 0;
    int            start[NB];
    logic [NB-1:0] m_prev = '0, m_sticky = '0;
    int            m_count = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // A repeat is due d cycles into a hold when d = RD + n*RR.
    task automatic drive_push(input logic [NB-1:0] db, input logic re,
                              input logic [NB-1:0] clr, input logic cc);
        logic [NB-1:0] p, r;
        int d;
        pbtn_db = db; rpt_en = re; evt_clr = clr; cnt_clr = cc;
        p = '0; r = '0;
        for (int i = 0; i < NB; i++) begin
            if (!m_prev[i] && db[i]) begin
                p[i] = 1; start[i] = t;
            end else if (m_prev[i] && !db[i]) begin
                r[i] = 1;
            end else if (m_prev[i] && db[i]) begin
                d = t - start[i];
                if (re && d >= RD && (d - RD) % RR == 0) p[i] = 1;
            end
        end
        m_sticky = (m_sticky & ~clr) | p;
        m_count  = (cc ? 0 : m_count) + $countones(p);
        if (m_count > 255) m_count = 255;
        m_prev = db;
        t++;
        q.push_back('{p, r, m_sticky, db, CW'(m_count)});
    endtask

    task automatic step(input logic [NB-1:0] db, input logic re = 1,
                        input logic [NB-1:0] clr = '0, input logic cc = 0);
        @(negedge clk);
        drive_push(db, re, clr, cc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_press"}, int'(press_pulse), 0);
        chk({tag, "_rel"}, int'(release_pulse), 0);
        chk({tag, "_sticky"}, int'(evt_sticky), 0);
        chk({tag, "_held"}, int'(btn_held), 0);
        chk({tag, "_count"}, int'(press_count), 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("press_pulse", int'(press_pulse), int'(e.press));
            chk("release_pulse", int'(release_pulse), int'(e.rel));
            chk("evt_sticky", int'(evt_sticky), int'(e.sticky));
            chk("btn_held", int'(btn_held), int'(e.held));
            chk("press_count", int'(press_count), int'(e.count));
        end
    end

    initial begin
        logic [NB-1:0] db;
        logic          re;
        #22;
        check_zero("reset");
        @(negedge clk);
        rst = 0;
        drive_push('0, 1, '0, 0);
        // single press held 8 cycles
        repeat (9) step('0);
        repeat (8) step(6'b000001);
        repeat (4) step('0);
        // auto-repeat, then the same with repeat disabled
        repeat (40) step(6'b001000, 1);
        repeat (3) step('0);
        repeat (40) step(6'b001000, 0);
        repeat (3) step('0);
        // release on the expiry edge
        repeat (20) step(6'b000100);
        repeat (3) step('0);
        // sticky clear, then clear racing a new press
        step(6'b000010);
        step('0);
        step('0, 1, 6'b111111);
        step(6'b000010, 1, 6'b000010);
        step('0);
        // counter saturation and clear together with presses
        step('0, 1, '0, 1);
        for (int n = 0; n < 254; n++) begin
            step(6'b000001);
            step('0);
        end
        step(6'b001110);
        step('0);
        step(6'b110000);
        step('0);
        step(6'b000011, 1, '0, 1);
        step('0);
        // async reset mid-REPEAT with a button still held
        repeat (30) step(6'b100000);
        @(posedge clk);
        #3 rst = 1;
        #1 check_zero("async_rst");
        m_prev = '0; m_sticky = '0; m_count = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        drive_push(6'b100000, 1, '0, 0);
        repeat (10) step(6'b100000);
        // random holds, repeat enable, clears
        db = '0; re = 1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NB; i++) if ($urandom_range(31) == 0) db[i] = ~db[i];
            if ($urandom_range(63) == 0) re = ~re;
            step(db, re, ($urandom_range(7) == 0) ? NB'($urandom) : '0, $urandom_range(99) == 0);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
